// File: rtl/sib_fifo_rd_ctrl.sv
// sib_fifo_rd_ctrl
// Read-side sequencer for one read port of the sib dual-clock FIFO.
// It runs entirely in the FIFO read-clock domain. It issues the FIFO read
// strobe and absorbs the memory read latency in a small skid buffer. It
// presents the words as a valid/ready stream, with optional fixed-length
// burst framing (m_last) and a flush that drains the FIFO.
//
// Optional feature (compile-time macro):
//   SIB_FIFO_RD_CTRL_TIMEOUT_EN - in burst mode, issue a partial burst after
//   TIMEOUT idle cycles with fewer than BURST_LEN words waiting. When the
//   macro is undefined, burst mode waits indefinitely for BURST_LEN words.
//
// Ports:
//   clk, rst            read-side clock, asynchronous active-high reset
//   fifo_empty          FIFO read-side empty flag
//   fifo_rdcnt          FIFO read-side occupancy (AWIDTH+1 bits, full legal)
//   fifo_rdata          FIFO read data, valid RD_LAT cycles after fifo_rd
//   fifo_rd             FIFO read strobe
//   burst_en            1 = burst mode, 0 = streaming; sampled only in IDLE
//   flush               level request to discard FIFO and pipeline contents
//   m_valid/m_ready     output stream handshake
//   m_data/m_last       output word and end-of-burst marker
//   busy                controller or pipeline not idle
//   flush_done          one-cycle pulse when a flush completes
module sib_fifo_rd_ctrl #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int RD_LAT    = 1,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [AWIDTH:0]   fifo_rdcnt,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd,
    input  logic              burst_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              flush_done
);

    localparam int SKID = RD_LAT + 2;
    localparam int PW   = $clog2(SKID);
    localparam int CW   = $clog2(SKID + 1);
    localparam int RW   = $clog2(BURST_LEN + 1);
    localparam logic [AWIDTH:0] BURST_CNT = (AWIDTH + 1)'(BURST_LEN);
    localparam logic [RW-1:0]   BURST_REM = RW'(BURST_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_FLUSH} state_t;

    state_t            state;
    logic [RW-1:0]     remaining;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_last;
    logic [DWIDTH-1:0] skid_data [SKID];
    logic              skid_last [SKID];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     inflight;
    logic              credit_ok;
    logic              rd_issue;
    logic              rd_last;
    logic              push;
    logic              pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + PW'(1);
    endfunction

    // Number of reads issued whose data has not yet reached the skid buffer.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(tag_valid[i]);
        end
    end

    // A read is only allowed if the skid buffer is guaranteed room for it
    // even when nothing is popped, so holding m_ready low never drops a word.
    assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < (CW + 1)'(SKID);

`ifdef SIB_FIFO_RD_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic          timer_arm;
    logic          timeout_fire;

    // Count IDLE cycles in burst mode where some words, but not a full
    // burst, are waiting. Any other cycle restarts the count.
    assign timer_arm    = (state == ST_IDLE) && burst_en && !flush && !fifo_empty &&
                          (fifo_rdcnt < BURST_CNT) && (fifo_rdcnt != '0);
    assign timeout_fire = timer_arm && (timer == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (timer_arm && !timeout_fire) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end
`endif

    // Read strobe per state. In FLUSH we drain without a credit check,
    // because the returning data is thrown away.
    always_comb begin
        rd_issue = 1'b0;
        case (state)
            ST_IDLE:  rd_issue = !burst_en && !flush && !fifo_empty && credit_ok;
            ST_BURST: rd_issue = !flush && !fifo_empty && credit_ok;
            ST_FLUSH: rd_issue = !fifo_empty;
            default:  rd_issue = 1'b0;
        endcase
    end

    assign rd_last = (state == ST_BURST) && (remaining == RW'(1));
    assign fifo_rd = rd_issue;

    // Tag pipeline that tracks each read through the memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= rd_issue;
            tag_last[0]  <= rd_issue && rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    assign push    = tag_valid[RD_LAT-1] && (state != ST_FLUSH);
    assign m_valid = (occ != '0) && (state != ST_FLUSH);
    assign pop     = m_valid && m_ready;

    // Skid pointers and occupancy. While flushing, the buffer is held empty
    // so that nothing stale survives into the next transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (state == ST_FLUSH) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + CW'(1);
            end else if (pop && !push) begin
                occ <= occ - CW'(1);
            end
        end
    end

    // Skid storage. It needs no reset because the outputs are gated by m_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            skid_data[wr_ptr] <= fifo_rdata;
            skid_last[wr_ptr] <= tag_last[RD_LAT-1];
        end
    end

    assign m_data = m_valid ? skid_data[rd_ptr] : '0;
    assign m_last = m_valid ? skid_last[rd_ptr] : 1'b0;
    assign busy   = (state != ST_IDLE) || (occ != '0) || (inflight != '0);

    // Control FSM: burst framing and flush sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                    end else if (burst_en && (fifo_rdcnt >= BURST_CNT)) begin
                        state     <= ST_BURST;
                        remaining <= BURST_REM;
                    end
`ifdef SIB_FIFO_RD_CTRL_TIMEOUT_EN
                    else if (timeout_fire) begin
                        state     <= ST_BURST;
                        remaining <= RW'(fifo_rdcnt);
                    end
`endif
                end
                ST_BURST: begin
                    if (flush) begin
                        state     <= ST_FLUSH;
                        remaining <= '0;
                    end else if (rd_issue) begin
                        remaining <= remaining - RW'(1);
                        if (rd_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty && (inflight == '0) && !flush) begin
                        state      <= ST_IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sib_fifo_rd_ctrl.sv
// tb_sib_fifo_rd_ctrl
// Directed bench for sib_fifo_rd_ctrl with the default parameters
// (DWIDTH=8, AWIDTH=4, RD_LAT=1, BURST_LEN=4). A behavioural 16-deep FIFO
// feeds the DUT. Words expected at the output are queued when written and
// are popped by a monitor on every handshake.
module tb_sib_fifo_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [AW:0]   fifo_rdcnt;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd;
    logic          burst_en = 1'b0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          flush_done;

    logic [DW-1:0] mem [16];
    int            fifo_wp = 0;
    int            fifo_rp = 0;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   rd_total     = 0;
    int   fd_total     = 0;
    int   hs_total     = 0;
    int   extra_words  = 0;

    sib_fifo_rd_ctrl #(
        .DWIDTH(DW), .AWIDTH(AW), .RD_LAT(1), .BURST_LEN(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_rdcnt(fifo_rdcnt), .fifo_rdata(fifo_rdata),
        .fifo_rd(fifo_rd), .burst_en(burst_en), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO read side with one cycle of read latency.
    assign fifo_empty = (fifo_wp == fifo_rp);
    assign fifo_rdcnt = (AW + 1)'(fifo_wp - fifo_rp);

    always @(posedge clk) begin
        if (fifo_rd && (fifo_wp != fifo_rp)) begin
            fifo_rdata <= mem[fifo_rp % 16];
            fifo_rp    <= fifo_rp + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (fifo_rd) begin
            rd_total++;
            checkOutput("rd_not_empty", 32'(fifo_empty), 32'd0);
        end
        if (flush_done) begin
            fd_total++;
        end
        if (!rst && m_valid && m_ready) begin
            hs_total++;
            if (exp_q.size() == 0) begin
                extra_words++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("m_data", 32'(m_data), 32'(e.data));
                checkOutput("m_last", 32'(m_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic be, input logic rdy, input logic fl);
        burst_en = be;
        m_ready  = rdy;
        flush    = fl;
    endtask

    task automatic pushExp(input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic writeFifo(input logic [DW-1:0] d, input bit expect_out, input logic last);
        mem[fifo_wp % 16] = d;
        fifo_wp = fifo_wp + 1;
        if (expect_out) begin
            pushExp(d, last);
        end
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done"}, 32'(n < budget), 32'd1);
        checkOutput({tag, "_no_extra"}, 32'(extra_words), 32'd0);
    endtask

    task automatic doFlush(input int hold, input string tag);
        int fd0;
        int n = 0;
        flush = 1'b1;
        fd0 = fd_total;
        repeat (hold) tick();
        flush = 1'b0;
        while (fd_total == fd0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        tick();
        checkOutput({tag, "_pulses"}, 32'(fd_total - fd0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rd0;
        int hs0;
        int k;

        // Reset values
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_m_last", 32'(m_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
        rst = 1'b0;
        tick();

        // Streaming: six words, two-cycle latency, one word per cycle
        for (int i = 0; i < 6; i++) writeFifo(8'(8'h11 + i), 1'b1, 1'b0);
        tick();
        checkOutput("stream_lat_c1", 32'(m_valid), 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            checkOutput("stream_valid", 32'(m_valid), 32'd1);
            tick();
        end
        checkOutput("stream_busy_low", 32'(busy), 32'd0);
        checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure with a full FIFO: reads stop at the skid depth
        applyStimulus(1'b0, 1'b0, 1'b0);
        rd0 = rd_total;
        for (int i = 0; i < 16; i++) writeFifo(8'(8'h20 + i), 1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("bp_reads", 32'(rd_total - rd0), 32'd3);
        checkOutput("bp_head_held", 32'(m_data), 32'h20);
        checkOutput("bp_fifo_level", 32'(fifo_rdcnt), 32'd13);
        m_ready = 1'b1;
        waitIdle(80, "bp");

        // Burst mode: three words wait, the fourth starts a framed burst
        applyStimulus(1'b1, 1'b1, 1'b0);
        rd0 = rd_total;
        for (int i = 0; i < 3; i++) writeFifo(8'(8'h31 + i), 1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("burst_wait_reads", 32'(rd_total - rd0), 32'd0);
        checkOutput("burst_wait_valid", 32'(m_valid), 32'd0);
        writeFifo(8'h34, 1'b1, 1'b1);
        waitIdle(30, "burst");
        checkOutput("burst_reads", 32'(rd_total - rd0), 32'd4);

        // Flush mid-burst after two reads, FIFO holding ten words
        applyStimulus(1'b1, 1'b0, 1'b0);
        rd0 = rd_total;
        for (int i = 0; i < 10; i++) writeFifo(8'(8'h40 + i), 1'b0, 1'b0);
        k = 0;
        while ((rd_total - rd0) < 2 && k < 20) begin
            tick();
            k++;
        end
        checkOutput("flush_two_reads", 32'(rd_total - rd0), 32'd2);
        flush = 1'b1;
        tick();
        checkOutput("flush_valid_low", 32'(m_valid), 32'd0);
        doFlush(2, "flush");
        checkOutput("flush_fifo_empty", 32'(fifo_rdcnt), 32'd0);
        checkOutput("flush_busy_low", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) writeFifo(8'(8'h51 + i), 1'b1, 1'(i == 3));
        waitIdle(40, "post_flush");

        // Partial burst: two words in burst mode
        applyStimulus(1'b1, 1'b1, 1'b0);
        rd0 = rd_total;
        hs0 = hs_total;
`ifdef SIB_FIFO_RD_CTRL_TIMEOUT_EN
        writeFifo(8'h61, 1'b1, 1'b0);
        writeFifo(8'h62, 1'b1, 1'b1);
        repeat (10) tick();
        checkOutput("to_early_reads", 32'(rd_total - rd0), 32'd0);
        waitIdle(60, "timeout");
        checkOutput("to_reads", 32'(rd_total - rd0), 32'd2);
`else
        writeFifo(8'h61, 1'b0, 1'b0);
        writeFifo(8'h62, 1'b0, 1'b0);
        repeat (100) tick();
        checkOutput("no_to_reads", 32'(rd_total - rd0), 32'd0);
        checkOutput("no_to_words", 32'(hs_total - hs0), 32'd0);
        checkOutput("no_to_level", 32'(fifo_rdcnt), 32'd2);
        doFlush(1, "no_to_cleanup");
`endif

        // Asynchronous reset mid-burst with m_ready low
        applyStimulus(1'b1, 1'b0, 1'b0);
        rd0 = rd_total;
        for (int i = 0; i < 8; i++) writeFifo(8'(8'h71 + i), 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("pre_rst_valid", 32'(m_valid), 32'd1);
        checkOutput("pre_rst_reads", 32'(rd_total - rd0), 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("arst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("arst_m_data", 32'(m_data), 32'd0);
        checkOutput("arst_m_last", 32'(m_last), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_flush_done", 32'(flush_done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        checkOutput("post_rst_level", 32'(fifo_rdcnt), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) pushExp(8'(8'h74 + i), 1'b0);
        waitIdle(40, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
